memoria_dados_resp: RTL

// - Data-memory responder for the nRisc data port: services the processor's MemRead/MemWrite

---
 rtl/memoria_dados_resp.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/memoria_dados_resp.sv
// Data-memory responder for the nRisc data port.
// Accepts a MemRead/MemWrite request in OCIOSO, waits WAIT_STATES cycles in ESPERA,
// then answers for exactly one cycle in RESPONDE with MemReady (and MemErro when the
// address is out of range or both MemRead and MemWrite were asserted).
// Optional feature macro: MMIO_SAIDA_EN maps address 8'hFF onto the SaidaIO register
// instead of RAM. Without it, 8'hFF is ordinary RAM and SaidaIO is tied to 8'h00.
module memoria_dados_resp #(
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [7:0] EnderecoDados,
  input  logic [7:0] DadoEscrito,
  input  logic       MemRead,
  input  logic       MemWrite,
  output logic [7:0] DadoLido,
  output logic       MemReady,
  output logic       MemErro,
  output logic [7:0] SaidaIO
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {Ocioso, Espera, Responde} estadoT;

  estadoT      estadoQ, estadoD;
  logic [3:0]  contadorQ, contadorD;
  logic [7:0]  enderecoQ, enderecoD;
  logic [7:0]  dadoQ, dadoD;
  logic        escritaQ, escritaD;
  logic        conflitoQ, conflitoD;

  logic [7:0]  mem [DEPTH];

  // Access currently being resolved: live inputs while idle, latched copy afterwards.
  logic [7:0]  curEndereco;
  logic [7:0]  curDado;
  logic        curEscrita;
  logic        entraResponde;
  logic        escreveRam;

  // 8'hFF is the output register only when the MMIO feature is built in.
  function automatic logic ehIO(input logic [7:0] a);
`ifdef MMIO_SAIDA_EN
    return a == 8'hFF;
`else
    return 1'b0 & (a == 8'hFF);
`endif
  endfunction

  // Out-of-range addresses never touch RAM; the MMIO address is always in range.
  function automatic logic foraDeFaixa(input logic [7:0] a);
    return !ehIO(a) && (32'(a) >= DEPTH);
  endfunction

  // Select the access operands depending on whether it is being accepted right now.
  always_comb begin
    curEndereco = enderecoQ;
    curDado     = dadoQ;
    curEscrita  = escritaQ;
    if (estadoQ == Ocioso) begin
      curEndereco = EnderecoDados;
      curDado     = DadoEscrito;
      curEscrita  = MemWrite;
    end
  end

  // Next-state logic: accept in OCIOSO, count down in ESPERA, single-cycle RESPONDE.
  always_comb begin
    estadoD   = estadoQ;
    contadorD = contadorQ;
    enderecoD = enderecoQ;
    dadoD     = dadoQ;
    escritaD  = escritaQ;
    conflitoD = conflitoQ;
    unique case (estadoQ)
      Ocioso: begin
        if (MemRead || MemWrite) begin
          enderecoD = EnderecoDados;
          dadoD     = DadoEscrito;
          escritaD  = MemWrite;
          conflitoD = MemRead && MemWrite;
          contadorD = 4'(WAIT_STATES);
          estadoD   = (WAIT_STATES > 0) ? Espera : Responde;
        end
      end
      Espera: begin
        if (contadorQ <= 4'd1) begin
          contadorD = 4'd0;
          estadoD   = Responde;
        end else begin
          contadorD = contadorQ - 4'd1;
        end
      end
      Responde: begin
        contadorD = 4'd0;
        estadoD   = Ocioso;
      end
      default: estadoD = Ocioso;
    endcase
  end

  // Writes land on the edge that enters RESPONDE; a reset on that edge drops them.
  always_comb begin
    entraResponde = (estadoD == Responde) && (estadoQ != Responde);
    escreveRam    = !Reset && entraResponde && curEscrita &&
                    !foraDeFaixa(curEndereco) && !ehIO(curEndereco);
  end

  // Control and access registers with synchronous reset.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      estadoQ   <= Ocioso;
      contadorQ <= 4'd0;
      enderecoQ <= 8'h00;
      dadoQ     <= 8'h00;
      escritaQ  <= 1'b0;
      conflitoQ <= 1'b0;
    end else begin
      estadoQ   <= estadoD;
      contadorQ <= contadorD;
      enderecoQ <= enderecoD;
      dadoQ     <= dadoD;
      escritaQ  <= escritaD;
      conflitoQ <= conflitoD;
    end
  end

  // Byte RAM; contents survive reset.
  always_ff @(posedge Clock) begin
    if (escreveRam) begin
      mem[curEndereco[AW-1:0]] <= curDado;
    end
  end

`ifdef MMIO_SAIDA_EN
  logic [7:0] saidaQ;

  // Output register updated on the commit edge of a write to 8'hFF.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      saidaQ <= 8'h00;
    end else if (entraResponde && curEscrita && ehIO(curEndereco)) begin
      saidaQ <= curDado;
    end
  end

  assign SaidaIO = saidaQ;
`else
  assign SaidaIO = 8'h00;
`endif

  // Response outputs; DadoLido stays at zero outside the RESPONDE cycle and for writes.
  always_comb begin
    MemReady = (estadoQ == Responde);
    MemErro  = MemReady && (conflitoQ || foraDeFaixa(enderecoQ));
    DadoLido = 8'h00;
    if (MemReady && !escritaQ) begin
`ifdef MMIO_SAIDA_EN
      if (ehIO(enderecoQ)) begin
        DadoLido = saidaQ;
      end else if (!foraDeFaixa(enderecoQ)) begin
        DadoLido = mem[enderecoQ[AW-1:0]];
      end
`else
      if (!foraDeFaixa(enderecoQ)) begin
        DadoLido = mem[enderecoQ[AW-1:0]];
      end
`endif
    end
  end

endmodule
